// File: rtl/key_debounce_multi.sv
// N-channel key debouncer: 2-flop sync, tick-sampled window, hysteresis, strobes.
// Optional long-press strobe enabled by defining KEY_LONG_PRESS_EN.
module key_debounce_multi #(
    parameter int N_KEYS     = 2,
    parameter int TICK_DIV   = 50000,
    parameter int SAMPLES    = 12,
    parameter int ACTIVE_LOW = 0,
    parameter int LONG_TICKS = 1000
) (
    input  logic              Sys_CLK,
    input  logic              Sys_RST_N,
    input  logic [N_KEYS-1:0] Key_In,
    output logic [N_KEYS-1:0] Key_Out,
    output logic [N_KEYS-1:0] Key_Press,
    output logic [N_KEYS-1:0] Key_Release,
    output logic [N_KEYS-1:0] Key_Long
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [N_KEYS-1:0] IDLE_PIN = {N_KEYS{ACTIVE_LOW != 0}};

    if (N_KEYS < 1 || TICK_DIV < 2 || SAMPLES < 2 || LONG_TICKS < 1) begin : g_bad_param
        $error("key_debounce_multi: illegal parameter value");
    end

    logic [TW-1:0]     cnt;
    logic              tick;
    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] s;

    assign tick = (cnt == TICK_MAX);

    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

    // Sync flops idle at the released pin level so reset exit looks like "not pressed".
    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= Key_In;
            sync2 <= sync1;
        end
    end

    assign s = sync2 ^ IDLE_PIN;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        logic [SAMPLES-2:0] hist;
        logic [SAMPLES-1:0] win;
        logic               out_q;
        logic               prs_q;
        logic               rel_q;

        // Window as it stands after this tick's sample is shifted in.
        assign win = {hist, s[gi]};

        always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
            if (!Sys_RST_N) begin
                hist  <= '0;
                out_q <= 1'b0;
                prs_q <= 1'b0;
                rel_q <= 1'b0;
            end else begin
                prs_q <= 1'b0;
                rel_q <= 1'b0;
                if (tick) begin
                    hist <= win[SAMPLES-2:0];
                    if (&win && !out_q) begin
                        out_q <= 1'b1;
                        prs_q <= 1'b1;
                    end else if (~|win && out_q) begin
                        out_q <= 1'b0;
                        rel_q <= 1'b1;
                    end
                end
            end
        end

        assign Key_Out[gi]     = out_q;
        assign Key_Press[gi]   = prs_q;
        assign Key_Release[gi] = rel_q;

`ifdef KEY_LONG_PRESS_EN
        localparam int LW = $clog2(LONG_TICKS + 1);
        localparam logic [LW-1:0] LMAX = LW'(LONG_TICKS);

        logic [LW-1:0] lc;
        logic          lng_q;

        // Saturating hold counter; one strobe per press.
        always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
            if (!Sys_RST_N) begin
                lc    <= '0;
                lng_q <= 1'b0;
            end else begin
                lng_q <= 1'b0;
                if (!out_q) begin
                    lc <= '0;
                end else if (tick && lc != LMAX) begin
                    lc    <= lc + LW'(1);
                    lng_q <= (lc == LMAX - LW'(1));
                end
            end
        end

        assign Key_Long[gi] = lng_q;
`else
        assign Key_Long[gi] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: run-length reference model plus directed literals.
// Key_Long expectations follow KEY_LONG_PRESS_EN.
module tb_key_debounce_multi;

    localparam int NK = 2;
    localparam int TD = 4;
    localparam int SM = 4;
    localparam int LT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NK-1:0] pa, pb;
    logic [NK-1:0] oa, pra, rla, lga;
    logic [NK-1:0] ob, prb, rlb, lgb;

    key_debounce_multi #(
        .N_KEYS(NK), .TICK_DIV(TD), .SAMPLES(SM),
        .ACTIVE_LOW(0), .LONG_TICKS(LT)
    ) dut_a (
        .Sys_CLK(clk), .Sys_RST_N(rst_n), .Key_In(pa),
        .Key_Out(oa), .Key_Press(pra), .Key_Release(rla), .Key_Long(lga)
    );

    key_debounce_multi #(
        .N_KEYS(NK), .TICK_DIV(TD), .SAMPLES(SM),
        .ACTIVE_LOW(1), .LONG_TICKS(LT)
    ) dut_b (
        .Sys_CLK(clk), .Sys_RST_N(rst_n), .Key_In(pb),
        .Key_Out(ob), .Key_Press(prb), .Key_Release(rlb), .Key_Long(lgb)
    );

    int checks = 0;
    int errors = 0;

    // Model: last sample value v with its run length r; state flips
    // once a run of SM equal samples disagrees with the current level.
    typedef struct {
        bit v;
        int r;
        bit out;
        bit prs;
        bit rel;
        bit lng;
        int lc;
        bit d0;
        bit d1;
    } ch_t;

    ch_t ma[NK];
    ch_t mb[NK];
    int  mcyc;
    int  ecnt;

    function automatic ch_t init_ch();
        ch_t c;
        c.v = 1'b0; c.r = SM; c.out = 1'b0;
        c.prs = 1'b0; c.rel = 1'b0; c.lng = 1'b0;
        c.lc = 0; c.d0 = 1'b0; c.d1 = 1'b0;
        return c;
    endfunction

    function automatic ch_t step(ch_t c, bit p, bit tick);
        ch_t n;
        bit  smp;
        n = c;
        n.prs = 1'b0; n.rel = 1'b0; n.lng = 1'b0;
        smp = c.d1;
        n.d1 = c.d0;
        n.d0 = p;
        if (!c.out) n.lc = 0;
        if (tick) begin
            if (smp == c.v) begin
                n.r = (c.r < SM) ? c.r + 1 : SM;
            end else begin
                n.v = smp;
                n.r = 1;
            end
            if (c.out && c.lc < LT) begin
                n.lc = c.lc + 1;
                if (n.lc == LT) n.lng = 1'b1;
            end
            if (n.r == SM && n.v != c.out) begin
                n.out = n.v;
                n.prs = n.v;
                n.rel = !n.v;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcyc <= 0;
            ecnt <= 0;
            for (int i = 0; i < NK; i++) begin
                ma[i] <= init_ch();
                mb[i] <= init_ch();
            end
        end else begin
            mcyc <= mcyc + 1;
            ecnt <= ecnt + 1;
            for (int i = 0; i < NK; i++) begin
                ma[i] <= step(ma[i], pa[i], (mcyc % TD) == TD - 1);
                mb[i] <= step(mb[i], !pb[i], (mcyc % TD) == TD - 1);
            end
        end
    end

    task automatic check(string nm, logic [NK-1:0] act, logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t edge=%0d got=%b expected=%b",
                     nm, $time, ecnt, act, exp);
        end
    endtask

    task automatic check_q(string nm, int q[$], int e[$]);
        bit bad;
        checks++;
        bad = (q.size() != e.size());
        if (!bad) begin
            foreach (q[k]) if (q[k] != e[k]) bad = 1'b1;
        end
        if (bad) begin
            errors++;
            $display("FAIL %s got=%p expected=%p", nm, q, e);
        end
    endtask

    function automatic logic [NK-1:0] pick(ch_t m[NK], int sel);
        logic [NK-1:0] v;
        for (int i = 0; i < NK; i++) begin
            case (sel)
                0:       v[i] = m[i].out;
                1:       v[i] = m[i].prs;
                2:       v[i] = m[i].rel;
                default: v[i] = m[i].lng;
            endcase
        end
        return v;
    endfunction

    function automatic logic [NK-1:0] long_exp(ch_t m[NK]);
`ifdef KEY_LONG_PRESS_EN
        return pick(m, 3);
`else
        return pick(m, 0) & '0;
`endif
    endfunction

    always @(negedge clk) begin
        check("A.out", oa, pick(ma, 0));
        check("A.press", pra, pick(ma, 1));
        check("A.release", rla, pick(ma, 2));
        check("A.long", lga, long_exp(ma));
        check("B.out", ob, pick(mb, 0));
        check("B.press", prb, pick(mb, 1));
        check("B.release", rlb, pick(mb, 2));
        check("B.long", lgb, long_exp(mb));
    end

    int ap0[$], ap1[$], ar0[$], ar1[$], al0[$], al1[$];
    int bp0[$], br0[$], bl0[$], bx1[$];
    bit log_en = 1'b1;

    always @(negedge clk) begin
        if (rst_n && log_en) begin
            if (pra[0]) ap0.push_back(ecnt);
            if (pra[1]) ap1.push_back(ecnt);
            if (rla[0]) ar0.push_back(ecnt);
            if (rla[1]) ar1.push_back(ecnt);
            if (lga[0]) al0.push_back(ecnt);
            if (lga[1]) al1.push_back(ecnt);
            if (prb[0]) bp0.push_back(ecnt);
            if (rlb[0]) br0.push_back(ecnt);
            if (lgb[0]) bl0.push_back(ecnt);
            if (prb[1] || rlb[1] || lgb[1]) bx1.push_back(ecnt);
        end
    end

    task automatic at(int e);
        int guard = 0;
        while (ecnt < e && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for edge %0d", e);
        end
    endtask

    initial begin
        int exp_l0[$];
        int exp_l1[$];
        int empty_q[$];
        pa = 2'b11;
        pb = 2'b11;
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check("rst.A.out", oa | pra | rla | lga, 2'b00);
        check("rst.B.out", ob | prb | rlb | lgb, 2'b00);
        rst_n = 1'b1;
        at(8);  pb[0] = 1'b0;
        at(15); check("A.out.pre16", oa, 2'b00);
        at(16); check("A.out.at16", oa, 2'b11);
        check("A.press.at16", pra, 2'b11);
        at(20); pa[0] = 1'b0;
        at(24); pa[0] = 1'b1;
        check("B.out.at24", ob, 2'b01);
        at(28); pa[0] = 1'b0;
        at(36); pb[0] = 1'b1;
        at(44); check("A.out.at44", oa, 2'b10);
        at(48); pa[1] = 1'b0;
        at(60); pa[1] = 1'b1;
        at(64); pa[1] = 1'b0;
        at(79); check("A.out.pre80", oa, 2'b10);
        at(80); pa = 2'b11;
        check("A.release.at80", rla, 2'b10);
        at(140);
        log_en = 1'b0;

`ifdef KEY_LONG_PRESS_EN
        exp_l0 = {128};
        exp_l1 = {48, 128};
`else
        exp_l0 = {};
        exp_l1 = {};
`endif
        empty_q = {};
        check_q("A.press0.edges", ap0, {16, 96});
        check_q("A.press1.edges", ap1, {16, 96});
        check_q("A.rel0.edges", ar0, {44});
        check_q("A.rel1.edges", ar1, {80});
        check_q("A.long0.edges", al0, exp_l0);
        check_q("A.long1.edges", al1, exp_l1);
        check_q("B.press0.edges", bp0, {24});
        check_q("B.rel0.edges", br0, {52});
        check_q("B.long0.edges", bl0, empty_q);
        check_q("B.ch1.events", bx1, empty_q);

        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst2.A", oa | pra | rla | lga, 2'b00);
        check("rst2.B", ob | prb | rlb | lgb, 2'b00);
        rst_n = 1'b1;
        repeat (24) @(negedge clk);
        check("rst2.A.out", oa, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
